switchbox_config_loader: RTL

- Streams a switch-box configuration image in fixed-width words over a valid/ready handshake.
- Assembles the words in a shadow register, then commits the whole image atomically to the 384-bit config_in of one SwitchBox tile.
- The SwitchBox therefore never sees a partially written configuration.
- Sits between the bitstream/configuration controller and each SwitchBox instance.

---
 rtl/kfpga_config_pkg.sv | 19 +
 rtl/switchbox_config_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/kfpga_config_pkg.sv
// Shared configuration types and constants for kFPGA tile loaders.
package kfpga_config_pkg;

    // SwitchBox image geometry: 64 muxes, each with a 6-bit select.
    localparam int SB_N_MUX         = 64;
    localparam int SB_MUX_SEL_WIDTH = 6;
    localparam int SB_CONFIG_WIDTH  = SB_N_MUX * SB_MUX_SEL_WIDTH;  // 384

    // Default width of one word on the configuration stream.
    localparam int SB_WORD_WIDTH    = 32;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } load_state_t;

endpackage

// File: rtl/switchbox_config_loader.sv
// Streams a SwitchBox configuration image in words into a shadow register and
// commits the complete image to config_out in one cycle, so the SwitchBox
// never observes a partially written configuration.
module switchbox_config_loader
    import kfpga_config_pkg::*;
#(
    parameter int CONFIG_WIDTH = SB_CONFIG_WIDTH,
    parameter int WORD_WIDTH   = SB_WORD_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [WORD_WIDTH-1:0]   word_in,
    input  logic                    word_valid,
    output logic                    word_ready,
    output logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    config_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    // Words per image is derived from the widths and never overridden.
    localparam int N_WORDS  = (CONFIG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int CNT_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int SHADOW_W = N_WORDS * WORD_WIDTH;

    load_state_t       state;
    load_state_t       state_next;
    logic [CNT_W-1:0]  word_cnt;
    logic [SHADOW_W-1:0] shadow;

    logic load_start;  // accepted start request in IDLE
    logic xfer;        // word handshake that is not overridden by abort
    logic last_word;   // counter points at the final word of the image

    assign load_start = (state == IDLE) && start && !abort;
    assign xfer       = (state == LOAD) && word_valid && !abort;
    assign last_word  = (word_cnt == CNT_W'(N_WORDS - 1));

    // word_ready is decoded from state so it drops the moment COMMIT is entered.
    assign word_ready = (state == LOAD);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; abort wins over a simultaneous word transfer.
    always_comb begin
        // NOTE: default first, so no path through the case leaves
        // state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = LOAD;
            LOAD: begin
                if (abort)                  state_next = IDLE;
                else if (xfer && last_word) state_next = COMMIT;
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word counter: cleared by an accepted start, holds on the last word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                  word_cnt <= '0;
        else if (load_start)        word_cnt <= '0;
        else if (xfer && !last_word) word_cnt <= word_cnt + 1'b1;
    end

    // Shadow register: each transfer fills the slot selected by the counter.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the shadow is a wide register, not a RAM, so it takes the
        // async reset like any other flop and cannot leak a stale image.
        if (reset) begin
            shadow <= '0;
        end else if (xfer) begin
            for (int k = 0; k < N_WORDS; k++) begin
                if (word_cnt == CNT_W'(k)) shadow[k*WORD_WIDTH +: WORD_WIDTH] <= word_in;
            end
        end
    end

    // Sticky abort flag, set by abort during LOAD, cleared by the next start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                           error <= 1'b0;
        else if (load_start)                 error <= 1'b0;
        else if ((state == LOAD) && abort)   error <= 1'b1;
    end

    // Atomic commit at the edge leaving COMMIT; done is a one-cycle pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            config_out   <= '0;
            config_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            if (state == COMMIT) begin
                config_out   <= shadow[CONFIG_WIDTH-1:0];
                config_valid <= 1'b1;
            end
        end
    end

endmodule
